// File: rtl/fxp_div_pkg.sv
// fxp_div_pkg: shared types and constants for the fxp_div fixed-point divider.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, default-width iteration/saturation constants and a
// clog2 helper used to size the iteration counter.
package fxp_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Constants for the default Q8.8 configuration; the divider derives its own
   // width-generic equivalents from its parameters.
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_FRAC_BIT   = 8;
   localparam int ITER           = DEF_DATA_WIDTH + DEF_FRAC_BIT;
   localparam logic [DEF_DATA_WIDTH-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [DEF_DATA_WIDTH-1:0] SAT_MIN = 16'h8000;

   // Smallest r with 2**r >= v.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fxp_div_step.sv
// fxp_div_step: one restoring-division step (shift in a dividend bit, trial subtract).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
// Ports: rem (partial remainder, always < dmag), din (next dividend bit, MSB first),
//        dmag (divisor magnitude), rem_nxt (updated remainder), qbit (quotient bit).
module fxp_div_step #(
   parameter int W = 17
) (
   input  logic [W-1:0] rem,
   input  logic         din,
   input  logic [W-1:0] dmag,
   output logic [W-1:0] rem_nxt,
   output logic         qbit
);

   logic [W+1:0] shifted;
   logic [W+1:0] diff;

   // Two spare top bits: one for the shifted-in position, one to catch the borrow.
   assign shifted = {1'b0, rem, din};
   assign diff    = shifted - {2'b00, dmag};
   assign qbit    = ~diff[W+1];

   // rem < dmag on entry, so either result fits back into W bits.
   assign rem_nxt = qbit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/fxp_div.sv
// fxp_div: sequential signed Q(DATA_WIDTH-FRAC_BIT).FRAC_BIT divider, quotient = (dividend << FRAC_BIT) / divisor.
// Latency: out_valid seen DATA_WIDTH+FRAC_BIT+1 edges after accept (+1 with FXP_DIV_ROUND_EN), 1 edge on divide-by-zero.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until the cycle after the output handshake.
// Ports: clk/reset (sync, active-high); in_valid/in_ready + dividend/divisor operands;
//        out_valid/out_ready + quotient, div_by_zero, saturated result.
// Optional: define FXP_DIV_ROUND_EN for round-half-away-from-zero via one extra guard-bit iteration.
module fxp_div
   import fxp_div_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BIT   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic                  div_by_zero,
   output logic                  saturated
);

   localparam int N  = DATA_WIDTH + FRAC_BIT;
`ifdef FXP_DIV_ROUND_EN
   localparam int STEPS = N + 1;   // extra step produces the guard bit
`else
   localparam int STEPS = N;
`endif
   localparam int CW = clog2(STEPS + 1);
   localparam int RW = DATA_WIDTH + 1;   // magnitude width, holds 2**(DATA_WIDTH-1) exactly
   localparam int MW = N + 1;            // quotient magnitude width

   localparam logic [CW-1:0]         LAST   = CW'(STEPS - 1);
   localparam logic [DATA_WIDTH-1:0] QMAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] QMIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [MW-1:0]         POSLIM = {{(FRAC_BIT+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [MW-1:0]         NEGLIM = {{(FRAC_BIT+1){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic              sign;
   logic [RW-1:0]     dmag;
   logic [N-1:0]      nshift;   // |dividend| << FRAC_BIT, consumed MSB first
   logic [RW-1:0]     rem;
   logic [STEPS-2:0]  qacc;     // quotient bits gathered so far

   logic [DATA_WIDTH-1:0] a_mag, b_mag_w;
   logic [RW-1:0]         b_mag;
   logic [N-1:0]          a_shift;
   logic                  b_zero;

   logic [RW-1:0]     step_rem;
   logic              step_q;
   logic [STEPS-1:0]  raw;
   logic [MW-1:0]     mag;
   logic [DATA_WIDTH-1:0] res_q;
   logic              res_sat;

   // Unsigned magnitudes: -2**(DATA_WIDTH-1) negates to itself, which read as
   // unsigned is exactly the right magnitude.
   assign a_mag   = dividend[DATA_WIDTH-1] ? -dividend : dividend;
   assign b_mag_w = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;
   assign b_mag   = {1'b0, b_mag_w};
   assign a_shift = {a_mag, {FRAC_BIT{1'b0}}};
   assign b_zero  = (divisor == '0);

   fxp_div_step #(.W(RW)) u_step (
      .rem     (rem),
      .din     (nshift[N-1]),
      .dmag    (dmag),
      .rem_nxt (step_rem),
      .qbit    (step_q)
   );

   // Full quotient including the bit produced this cycle; only used on the last step.
   assign raw = {qacc, step_q};

`ifdef FXP_DIV_ROUND_EN
   assign mag = {1'b0, raw[STEPS-1:1]} + {{N{1'b0}}, raw[0]};
`else
   assign mag = {1'b0, raw};
`endif

   always_comb begin
      res_q   = '0;
      res_sat = 1'b0;
      if (!sign) begin
         if (mag > POSLIM) begin
            res_q   = QMAX;
            res_sat = 1'b1;
         end else begin
            res_q = mag[DATA_WIDTH-1:0];
         end
      end else begin
         if (mag > NEGLIM) begin
            res_q   = QMIN;
            res_sat = 1'b1;
         end else begin
            // mag == 0 negates to 0, so a zero result never carries a sign.
            res_q = -mag[DATA_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = b_zero ? DONE : CALC;
         end
         CALC: begin
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         sign        <= 1'b0;
         dmag        <= '0;
         nshift      <= '0;
         rem         <= '0;
         qacc        <= '0;
         quotient    <= '0;
         div_by_zero <= 1'b0;
         saturated   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign   <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                  dmag   <= b_mag;
                  nshift <= a_shift;
                  rem    <= '0;
                  qacc   <= '0;
                  cnt    <= '0;
                  if (b_zero) begin
                     quotient    <= dividend[DATA_WIDTH-1] ? QMIN : QMAX;
                     div_by_zero <= 1'b1;
                     saturated   <= 1'b1;
                  end
               end
            end
            CALC: begin
               rem    <= step_rem;
               nshift <= {nshift[N-2:0], 1'b0};
               qacc   <= raw[STEPS-2:0];
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  quotient    <= res_q;
                  saturated   <= res_sat;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fxp_div.sv
module tb_fxp_div;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic        div_by_zero;
   logic        saturated;

   int tests;
   int fails;

`ifdef FXP_DIV_ROUND_EN
   localparam int LAT = 26;
   localparam bit RND = 1'b1;
`else
   localparam int LAT = 25;
   localparam bit RND = 1'b0;
`endif

   fxp_div #(.DATA_WIDTH(16), .FRAC_BIT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .div_by_zero (div_by_zero),
      .saturated   (saturated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic        dbz;
      logic        sat;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one operand pair, wait (bounded) for the result, optionally ack it.
   logic [15:0] r_q;
   logic        r_dbz, r_sat, r_ir;
   int          r_lat;

   task automatic run_div(input logic [15:0] a, input logic [15:0] b, input bit ack);
      @(negedge clk);
      r_ir     = in_ready;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      r_lat = 0;
      while (1) begin
         @(negedge clk);
         r_lat++;
         if (out_valid) break;
         if (r_lat >= 100) begin
            r_lat = -1;
            break;
         end
      end
      r_q   = quotient;
      r_dbz = div_by_zero;
      r_sat = saturated;
      if (ack && r_lat > 0) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;

      vecs[0]  = '{"3.0/1.5",        16'h0300, 16'h0180, 16'h0200, 1'b0, 1'b0, LAT};
      vecs[1]  = '{"-1.0/4.0",       16'hFF00, 16'h0400, 16'hFFC0, 1'b0, 1'b0, LAT};
      vecs[2]  = '{"2.0/3.0",        16'h0200, 16'h0300, RND ? 16'h00AB : 16'h00AA, 1'b0, 1'b0, LAT};
      vecs[3]  = '{"1.0/0",          16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1};
      vecs[4]  = '{"-1.0/0",         16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1, 1};
      vecs[5]  = '{"0/0",            16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1};
      vecs[6]  = '{"127/lsb",        16'h7F00, 16'h0001, 16'h7FFF, 1'b0, 1'b1, LAT};
      vecs[7]  = '{"-128/1.0",       16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, LAT};
      vecs[8]  = '{"-lsb/3.0 zero",  16'hFFFF, 16'h0300, 16'h0000, 1'b0, 1'b0, LAT};
      vecs[9]  = '{"lsb/2.0 half",   16'h0001, 16'h0200, RND ? 16'h0001 : 16'h0000, 1'b0, 1'b0, LAT};
      vecs[10] = '{"-lsb/2.0 half",  16'hFFFF, 16'h0200, RND ? 16'hFFFF : 16'h0000, 1'b0, 1'b0, LAT};
      vecs[11] = '{"-1.0/-1.0",      16'hFF00, 16'hFF00, 16'h0100, 1'b0, 1'b0, LAT};
      vecs[12] = '{"0.5/-1.0",       16'h0080, 16'hFF00, 16'hFF80, 1'b0, 1'b0, LAT};
      vecs[13] = '{"-128/-1.0",      16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1, LAT};
      vecs[14] = '{"-128/-128",      16'h8000, 16'h8000, 16'h0100, 1'b0, 1'b0, LAT};
      vecs[15] = '{"0/4.0",          16'h0000, 16'h0400, 16'h0000, 1'b0, 1'b0, LAT};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready",    {31'b0, in_ready},    32'd1);
      check("reset out_valid",   {31'b0, out_valid},   32'd0);
      check("reset quotient",    {16'b0, quotient},    32'd0);
      check("reset div_by_zero", {31'b0, div_by_zero}, 32'd0);
      check("reset saturated",   {31'b0, saturated},   32'd0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_div(vecs[i].a, vecs[i].b, 1'b1);
         check({vecs[i].name, " in_ready"}, {31'b0, r_ir},  32'd1);
         check({vecs[i].name, " quotient"}, {16'b0, r_q},   {16'b0, vecs[i].q});
         check({vecs[i].name, " dbz"},      {31'b0, r_dbz}, {31'b0, vecs[i].dbz});
         check({vecs[i].name, " sat"},      {31'b0, r_sat}, {31'b0, vecs[i].sat});
         check({vecs[i].name, " latency"},  r_lat,          vecs[i].lat);
      end

      // Backpressure: result held for 5 cycles while in_valid pulses are offered.
      run_div(16'h0200, 16'h0300, 1'b0);
      check("bp latency", r_lat, LAT);
      for (int i = 0; i < 5; i++) begin
         check("bp quotient",  {16'b0, quotient},    RND ? 32'h00AB : 32'h00AA);
         check("bp dbz",       {31'b0, div_by_zero}, 32'd0);
         check("bp sat",       {31'b0, saturated},   32'd0);
         check("bp out_valid", {31'b0, out_valid},   32'd1);
         check("bp in_ready",  {31'b0, in_ready},    32'd0);
         in_valid = (i % 2 == 0);
         dividend = 16'h1234;
         divisor  = 16'h0000;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("bp held quotient", {16'b0, quotient}, RND ? 32'h00AB : 32'h00AA);
      check("bp held dbz",      {31'b0, div_by_zero}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("bp after ack in_ready",  {31'b0, in_ready},  32'd1);
      check("bp after ack out_valid", {31'b0, out_valid}, 32'd0);

      // Reset in the middle of an iteration, then a clean division.
      @(negedge clk);
      dividend = 16'h7F00;
      divisor  = 16'h0001;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("midcalc in_ready", {31'b0, in_ready}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst in_ready",    {31'b0, in_ready},    32'd1);
      check("rst out_valid",   {31'b0, out_valid},   32'd0);
      check("rst quotient",    {16'b0, quotient},    32'd0);
      check("rst div_by_zero", {31'b0, div_by_zero}, 32'd0);
      check("rst saturated",   {31'b0, saturated},   32'd0);
      reset = 1'b0;
      run_div(16'h0300, 16'h0180, 1'b1);
      check("post-rst quotient", {16'b0, r_q},   32'h0200);
      check("post-rst sat",      {31'b0, r_sat}, 32'd0);
      check("post-rst latency",  r_lat,          LAT);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
